// File: rtl/alu_pipe_mc.sv
// alu_pipe_mc: handshaked ALU that sits between operand fetch and writeback.
// It accepts one operation per transaction and returns a registered result with flags.
// Logic, add/sub, compare and illegal opcodes take one cycle.
// MUL is an unsigned shift-add over WIDTH cycles and returns a 2*WIDTH product.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-low reset; aborts any operation in flight
//   in_valid     request valid
//   in_ready     request channel ready (high only in IDLE)
//   src1, src2   operands
//   alu_control  4-bit opcode
//   out_valid    result valid
//   out_ready    consumer accepts result
//   result       result (low half for MUL)
//   result_hi    MUL high half, 0 otherwise
//   zero         result == 0
//   cout         carry out (ADD/SUB only)
//   overflow     signed overflow (ADD/SUB), result_hi != 0 (MUL)
//   illegal      opcode outside the supported set
module alu_pipe_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             illegal
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpMul  = 4'b0011;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSltu = 4'b1000;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpNand = 4'b1101;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 zero_q, zero_d;
    logic                 cout_q, cout_d;
    logic                 overflow_q, overflow_d;
    logic                 illegal_q, illegal_d;

    // Single-cycle datapath
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     op_res;
    logic                 op_cout;
    logic                 op_ov;
    logic                 op_ill;
    logic [2*WIDTH-1:0]   acc_sum;

    always_comb begin
        sum     = {1'b0, src1} + {1'b0, src2};
        diff    = {1'b0, src1} + {1'b0, ~src2} + (WIDTH + 1)'(1);
        op_res  = '0;
        op_cout = 1'b0;
        op_ov   = 1'b0;
        op_ill  = 1'b0;
        unique case (alu_control)
            OpAnd:  op_res = src1 & src2;
            OpOr:   op_res = src1 | src2;
            OpNor:  op_res = ~(src1 | src2);
            OpNand: op_res = ~(src1 & src2);
            OpAdd: begin
                op_res  = sum[WIDTH-1:0];
                op_cout = sum[WIDTH];
                op_ov   = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OpSub: begin
                // cout = 1 means no borrow
                op_res  = diff[WIDTH-1:0];
                op_cout = diff[WIDTH];
                op_ov   = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
            end
            OpSlt:  op_res = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
            OpSltu: op_res = {{(WIDTH-1){1'b0}}, src1 < src2};
            default: op_ill = 1'b1;
        endcase
    end

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        cout_d      = cout_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (alu_control == OpMul) begin
                        mcand_d  = {{WIDTH{1'b0}}, src1};
                        mplier_d = src2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        result_d    = op_res;
                        result_hi_d = '0;
                        zero_d      = (op_res == '0);
                        cout_d      = op_cout;
                        overflow_d  = op_ov;
                        illegal_d   = op_ill;
                        state_d     = StDone;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Outputs change only on the final step so no partial product is shown
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d    = acc_sum[WIDTH-1:0];
                    result_hi_d = acc_sum[2*WIDTH-1:WIDTH];
                    zero_d      = (acc_sum[WIDTH-1:0] == '0);
                    cout_d      = 1'b0;
                    overflow_d  = (acc_sum[2*WIDTH-1:WIDTH] != '0);
                    illegal_d   = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe_mc.sv
// Self-checking bench for alu_pipe_mc: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_alu_pipe_mc;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   alu_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         cout;
    logic         overflow;
    logic         illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe_mc #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src1        (src1),
        .src2        (src2),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: results straight from the arithmetic definition of each opcode.
    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         ov;
        logic         il;
    } exp_t;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = '0; e.hi = '0; e.c = 1'b0; e.ov = 1'b0; e.il = 1'b0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b1101: e.res = ~(a & b);
            4'b0010: begin
                p     = 64'(a) + 64'(b);
                e.res = p[W-1:0];
                e.c   = p[W];
                s     = sa + sb;
                e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                e.res = a - b;
                e.c   = (a >= b);
                s     = sa - sb;
                e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: e.res = (sa < sb) ? 1 : 0;
            4'b1000: e.res = (a < b) ? 1 : 0;
            4'b0011: begin
                p     = 64'(a) * 64'(b);
                e.res = p[W-1:0];
                e.hi  = p[63:W];
                e.ov  = (e.hi != 0);
            end
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, ".result"}, 64'(result), 64'(e.res));
        check({tag, ".result_hi"}, 64'(result_hi), 64'(e.hi));
        check({tag, ".flags"}, {60'd0, zero, cout, overflow, illegal},
              {60'd0, e.z, e.c, e.ov, e.il});
    endtask

    // Issue one op, check latency, outputs, hold under backpressure and release.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        exp_t e;
        int   lat;
        int   exp_lat;
        e       = model(op, a, b);
        exp_lat = (op == 4'b0011) ? W + 1 : 1;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; src1 = a; src2 = b; alu_control = op;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; they must be ignored
        in_valid = 1'b1; src1 = $urandom; src2 = $urandom; alu_control = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) begin
                check({tag, ".busy_in_ready"}, 64'(in_ready), 64'd0);
            end
        end while (!out_valid && lat < 200);
        in_valid = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check_outs(tag, e);
        check({tag, ".done_in_ready"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            check_outs({tag, ".hold"}, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".release"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    logic [3:0] ops [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101,
                            4'b0111, 4'b1000, 4'b0011, 4'b1111, 4'b0100, 4'b1010};

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; alu_control = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.handshake", {62'd0, in_ready, out_valid}, 64'b10);
        check("reset.result", {result_hi, result}, 64'd0);
        check("reset.flags", {60'd0, zero, cout, overflow, illegal}, 64'd0);
        rst = 1'b1;

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op("sub_eq", 4'b0110, 32'd5, 32'd5, 0);
        run_op("sub_borrow", 4'b0110, 32'd0, 32'd1, 0);
        run_op("mul_hi", 4'b0011, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("and_bp", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 4);
        run_op("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sltu", 4'b1000, 32'hFFFF_FFFF, 32'd1, 0);

        // Reset in the middle of a MUL
        @(negedge clk);
        in_valid = 1'b1; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678; alu_control = 4'b0011;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst.handshake", {62'd0, in_ready, out_valid}, 64'b10);
        check("mid_rst.result", {result_hi, result}, 64'd0);
        check("mid_rst.flags", {60'd0, zero, cout, overflow, illegal}, 64'd0);
        rst = 1'b1;
        run_op("post_rst_add", 4'b0010, 32'd3, 32'd4, 0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 11)], pick_operand(),
                   pick_operand(), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe_mc.md
Name: alu_pipe_mc

Overview:
Parametrised, handshaked successor to the team's single-cycle ALU. It accepts one operation per transaction on a valid/ready input channel and returns the registered result plus flags on a valid/ready output channel. Logic and add/sub ops complete in one cycle. MUL runs as an iterative shift-add over WIDTH cycles and returns a full 2*WIDTH product. The block sits between operand fetch and writeback in the datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, MUL iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-low
in_valid  in  1  operation request valid
in_ready  out  1  block can accept a request (high only in IDLE)
src1  in  WIDTH  operand 1
src2  in  WIDTH  operand 2
alu_control  in  4  opcode
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  result (low half for MUL)
result_hi  out  WIDTH  MUL high half; 0 for all other ops
zero  out  1  result==0 (low half only)
cout  out  1  carry out (ADD/SUB only)
overflow  out  1  signed overflow (ADD/SUB); result_hi!=0 (MUL)
illegal  out  1  opcode not in the supported set

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 1101 NAND
  - 0111 SLT signed: 1 if $signed(src1)<$signed(src2)
  - 1000 SLTU unsigned
  - 0011 MUL unsigned
  - Any other code is illegal.
- Reset (rst==0 at a rising edge): state=IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, zero=0, cout=0, overflow=0, illegal=0, counter=0. Reset aborts any op in flight; no partial result is ever presented.
- States: IDLE, MUL, DONE.
  - IDLE: in_ready=1. Accept occurs when in_valid&&in_ready. Operands and opcode are latched at accept.
  - Non-MUL accept: outputs are computed and registered that edge; next state DONE. Latency: out_valid high 1 cycle after accept.
  - MUL accept: multiplicand, multiplier and a 2*WIDTH accumulator are latched; counter=0; next state MUL.
  - MUL: each cycle, if multiplier LSB is set, add the shifted multiplicand to the accumulator; shift; counter++. When counter reaches WIDTH-1 that cycle, go to DONE with {result_hi,result}=product. out_valid is high exactly WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1 and in_ready=0. All outputs hold stable while out_ready==0. When out_ready==1, go to IDLE and drop out_valid next cycle. There is no same-cycle re-accept; throughput is at most 1 op per 2 cycles.
- Arithmetic:
  - ADD: {cout,result} = src1+src2 at WIDTH+1 bits. overflow = (src1[MSB]==src2[MSB]) && (result[MSB]!=src1[MSB]).
  - SUB: {cout,result} = src1 + ~src2 + 1, so cout=1 means no borrow (src1>=src2 unsigned). overflow = (src1[MSB]!=src2[MSB]) && (result[MSB]!=src1[MSB]).
  - Logic/SLT/SLTU/MUL: cout=0.
  - Logic/SLT/SLTU: overflow=0.
- Illegal opcode: completes like a 1-cycle op with result=0, result_hi=0, zero=1, cout=0, overflow=0, illegal=1. illegal=0 for all legal ops.
- zero is computed from result only, on every op.
- in_valid and operands are ignored outside IDLE; changes during MUL/DONE have no effect.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result=0x80000000, overflow=1, cout=0, zero=0, out_valid 1 cycle after accept.
- SUB 5 - 5 -> result=0, zero=1, cout=1, overflow=0. SUB 0 - 1 -> result=0xFFFFFFFF, cout=0.
- MUL 0xFFFFFFFF * 2 -> result=0xFFFFFFFE, result_hi=0x1, overflow=1; out_valid asserts exactly 33 cycles after accept; in_ready=0 throughout.
- Backpressure: complete an AND with out_ready=0 for 4 cycles -> out_valid, result and flags stay stable and in_ready stays 0. Raise out_ready -> IDLE next cycle.
- Reset mid-MUL: rst=0 at cycle 10 of a MUL -> next edge: in_ready=1, out_valid=0, all outputs 0. A new ADD 3+4 afterwards returns 7.
- Illegal opcode 1111 -> illegal=1, result=0, zero=1. SLT 0xFFFFFFFF vs 1 -> result=1; SLTU with the same operands -> result=0.
